// File: rtl/score_keeper.sv
// Whack-a-mole round controller: times one round off the 1 ms tick, keeps a
// saturating binary score and the session high score for the HEX display driver.
module score_keeper #(
    parameter int unsigned GAME_S       = 30,
    parameter int unsigned HIT_POINTS   = 10,
    parameter int unsigned MISS_PENALTY = 5,
    parameter int unsigned SCORE_MAX    = 99999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        oneMsPulse,
    input  logic        start,
    input  logic        hit,
    input  logic        miss,
    output logic [23:0] score,
    output logic [23:0] highscore,
    output logic [7:0]  time_left,
    output logic        game_active,
    output logic        game_over,
    output logic        new_high
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] score_q, score_d;
    logic [23:0] high_q, high_d;
    logic [7:0]  time_q, time_d;
    logic [9:0]  ms_q, ms_d;
    logic        first_q, first_d;
    logic        new_high_q, new_high_d;

    logic signed [25:0] delta;
    logic signed [25:0] sum;
    logic [23:0]        score_clamped;

    // Net delta is applied once when hit and miss coincide, then clamped.
    always_comb begin
        delta = (hit  ? $signed(26'(HIT_POINTS))   : 26'sd0)
              - (miss ? $signed(26'(MISS_PENALTY)) : 26'sd0);
        sum   = $signed({2'b00, score_q}) + delta;
        if (sum < 26'sd0) begin
            score_clamped = '0;
        end else if (sum > $signed(26'(SCORE_MAX))) begin
            score_clamped = 24'(SCORE_MAX);
        end else begin
            score_clamped = sum[23:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        time_d     = time_q;
        ms_d       = ms_q;
        first_d    = first_q;
        new_high_d = new_high_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PLAY;
                    score_d = '0;
                    time_d  = 8'(GAME_S);
                    ms_d    = '0;
                end
            end
            S_PLAY: begin
                score_d = score_clamped;
                if (oneMsPulse) begin
                    if (ms_q == 10'd999) begin
                        ms_d   = '0;
                        time_d = time_q - 8'd1;
                        if (time_q == 8'd1) begin
                            state_d = S_OVER;
                            first_d = 1'b1;
                        end
                    end else begin
                        ms_d = ms_q + 10'd1;
                    end
                end
            end
            S_OVER: begin
                first_d = 1'b0;
                if (first_q) begin
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end else begin
                        new_high_d = 1'b0;
                    end
                end
                // A restart in the first OVER cycle keeps the compare above.
                if (start) begin
                    state_d    = S_PLAY;
                    score_d    = '0;
                    time_d     = 8'(GAME_S);
                    ms_d       = '0;
                    new_high_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            time_q     <= '0;
            ms_q       <= '0;
            first_q    <= 1'b0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            time_q     <= time_d;
            ms_q       <= ms_d;
            first_q    <= first_d;
            new_high_q <= new_high_d;
        end
    end

    assign score       = score_q;
    assign highscore   = high_q;
    assign time_left   = time_q;
    assign game_active = (state_q == S_PLAY);
    assign game_over   = (state_q == S_OVER);
    assign new_high    = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus random play, checked against
// a round-level model (score clamp, tick count per round, high-score bookkeeping).
module tb_score_keeper;

    localparam int GS   = 2;
    localparam int HIT  = 10;
    localparam int MISS = 5;
    localparam int SMAX = 99999;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    logic        miss = 1'b0;
    logic [23:0] score;
    logic [23:0] highscore;
    logic [7:0]  time_left;
    logic        game_active;
    logic        game_over;
    logic        new_high;
    logic [59:0] act_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 idle, 1 play, 2 over; round progress kept as ticks since start.
    int m_state = 0;
    int m_score = 0;
    int m_high  = 0;
    int m_ticks = 0;
    bit m_first = 1'b0;
    bit m_nh    = 1'b0;

    score_keeper #(
        .GAME_S       (GS),
        .HIT_POINTS   (HIT),
        .MISS_PENALTY (MISS),
        .SCORE_MAX    (SMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .oneMsPulse  (tick),
        .start       (start),
        .hit         (hit),
        .miss        (miss),
        .score       (score),
        .highscore   (highscore),
        .time_left   (time_left),
        .game_active (game_active),
        .game_over   (game_over),
        .new_high    (new_high)
    );

    always #5 clk = ~clk;

    assign act_vec = {score, highscore, time_left, game_active, game_over, new_high};

    function automatic int clamp_score(input int v);
        if (v < 0) return 0;
        if (v > SMAX) return SMAX;
        return v;
    endfunction

    function automatic logic [59:0] exp_vec();
        int tl;
        tl = (m_state == 1) ? GS - m_ticks / 1000 : 0;
        return {24'(m_score), 24'(m_high), 8'(tl), m_state == 1, m_state == 2, m_nh};
    endfunction

    task automatic step(input bit r, input bit s, input bit h, input bit m, input bit t);
        reset = r; start = s; hit = h; miss = m; tick = t;
        @(posedge clk);
        if (r) begin
            m_state = 0; m_score = 0; m_high = 0; m_ticks = 0; m_first = 0; m_nh = 0;
        end else begin
            case (m_state)
                0: if (s) begin m_state = 1; m_score = 0; m_ticks = 0; end
                1: begin
                    m_score = clamp_score(m_score + (h ? HIT : 0) - (m ? MISS : 0));
                    if (t) begin
                        m_ticks++;
                        if (m_ticks == GS * 1000) begin m_state = 2; m_first = 1; end
                    end
                end
                default: begin
                    if (m_first) begin
                        m_nh = (m_score > m_high);
                        if (m_score > m_high) m_high = m_score;
                        m_first = 0;
                    end
                    if (s) begin m_state = 1; m_score = 0; m_ticks = 0; m_nh = 0; end
                end
            endcase
        end
        #1;
        reset = 0; start = 0; hit = 0; miss = 0; tick = 0;
    endtask

    task automatic play_round(input int nh, input int nm);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < nh; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < nm; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < GS * 1000; i++) step(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (act_vec !== 60'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, expected 0", act_vec);
        end
        step(0, 0, 1, 0, 1);
        n_checks++;
        if (score !== 24'd0 || game_active !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hit_ignored: score=%0d active=%0b, expected 0/0", score, game_active);
        end
    endtask

    task automatic test_scoring();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (score !== 24'd25 || game_active !== 1'b1 || time_left !== 8'd2) begin
            n_fail++;
            $display("FAIL score_25: score=%0d active=%0b tl=%0d, expected 25/1/2",
                     score, game_active, time_left);
        end
        step(0, 0, 1, 1, 0);
        n_checks++;
        if (score !== 24'd30 || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL hit_and_miss: score=%0d vec=%h, expected 30 vec=%h", score, act_vec, exp_vec());
        end
    endtask

    task automatic test_floor_saturate();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (score !== 24'd0) begin
            n_fail++;
            $display("FAIL floor_zero: score=%0d, expected 0", score);
        end
        for (int i = 0; i < 9999; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        n_checks++;
        if (score !== 24'd99995) begin
            n_fail++;
            $display("FAIL reach_99995: score=%0d, expected 99995", score);
        end
        step(0, 0, 1, 0, 0);
        n_checks++;
        if (score !== 24'd99999) begin
            n_fail++;
            $display("FAIL saturate: score=%0d, expected 99999", score);
        end
        step(0, 0, 1, 0, 0);
        n_checks++;
        if (score !== 24'd99999 || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL saturate_hold: vec=%h, expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_timing();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);  // tick coincident with start is not counted
        for (int i = 1; i <= GS * 1000; i++) begin
            step(0, 0, (i == GS * 1000), 0, 1);
            if (i == 999) begin
                n_checks++;
                if (time_left !== 8'd2) begin
                    n_fail++;
                    $display("FAIL tick999: time_left=%0d, expected 2", time_left);
                end
            end else if (i == 1000) begin
                n_checks++;
                if (time_left !== 8'd1) begin
                    n_fail++;
                    $display("FAIL tick1000: time_left=%0d, expected 1", time_left);
                end
            end else if (i == 1999) begin
                n_checks++;
                if (time_left !== 8'd1 || game_over !== 1'b0 || game_active !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tick1999: tl=%0d over=%0b active=%0b, expected 1/0/1",
                             time_left, game_over, game_active);
                end
            end
        end
        n_checks++;
        if (time_left !== 8'd0 || game_over !== 1'b1 || game_active !== 1'b0 || score !== 24'd10) begin
            n_fail++;
            $display("FAIL timeout: tl=%0d over=%0b active=%0b score=%0d, expected 0/1/0/10",
                     time_left, game_over, game_active, score);
        end
        step(0, 0, 1, 1, 1);
        n_checks++;
        if (score !== 24'd10 || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL over_ignores_input: vec=%h, expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_high_score();
        step(1, 0, 0, 0, 0);
        play_round(4, 0);
        n_checks++;
        if (game_over !== 1'b1 || highscore !== 24'd0) begin
            n_fail++;
            $display("FAIL high_lag: over=%0b high=%0d, expected 1/0", game_over, highscore);
        end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (highscore !== 24'd40 || new_high !== 1'b1) begin
            n_fail++;
            $display("FAIL round1_high: high=%0d nh=%0b, expected 40/1", highscore, new_high);
        end
        play_round(4, 0);
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (highscore !== 24'd40 || new_high !== 1'b0) begin
            n_fail++;
            $display("FAIL round2_tie: high=%0d nh=%0b, expected 40/0", highscore, new_high);
        end
        play_round(2, 1);
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (highscore !== 24'd40 || new_high !== 1'b0 || score !== 24'd15) begin
            n_fail++;
            $display("FAIL round3_lower: high=%0d nh=%0b score=%0d, expected 40/0/15",
                     highscore, new_high, score);
        end
        play_round(6, 0);
        step(0, 1, 0, 0, 0);  // start in first OVER cycle
        n_checks++;
        if (highscore !== 24'd60 || new_high !== 1'b0 || game_active !== 1'b1 || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL start_first_over: vec=%h, expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 1000; i++) step(0, 0, 0, 0, 1);
        n_checks++;
        if (time_left !== 8'd1 || score !== 24'd20) begin
            n_fail++;
            $display("FAIL mid_round_state: tl=%0d score=%0d, expected 1/20", time_left, score);
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (time_left !== 8'd1 || score !== 24'd20) begin
            n_fail++;
            $display("FAIL start_in_play: tl=%0d score=%0d, expected 1/20", time_left, score);
        end
        step(1, 0, 1, 0, 1);
        n_checks++;
        if (act_vec !== 60'h0) begin
            n_fail++;
            $display("FAIL reset_mid_round: got %h, expected 0", act_vec);
        end
    endtask

    task automatic test_random();
        bit s, h, m, t;
        int errs;
        errs = 0;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7000; i++) begin
            s = ($urandom % 400) == 0;
            h = ($urandom % 3) == 0;
            m = ($urandom % 5) == 0;
            t = ($urandom % 2) == 0;
            step(0, s, h, m, t);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle_%0d: got %h, expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scoring();
        test_floor_saturate();
        test_timing();
        test_high_score();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
